// File: rtl/enigma_pkg.sv
// -----------------------------------------------------------------------------
// enigma_pkg
//   Definitions shared by the Enigma UART receive/transmit path and benches.
//   - UART_CLKS_PER_BIT_DEFAULT : 115200 baud at a 12 MHz system clock
//   - uart_rx_state_t           : UART framing FSM states
//   - maj3                      : 2-of-3 majority vote
// -----------------------------------------------------------------------------
package enigma_pkg;

    localparam int UART_CLKS_PER_BIT_DEFAULT = 104;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for a single asynchronous input.
//   Ports:
//     clk    in  destination clock
//     rst_n  in  asynchronous active-low reset (both flops load RESET_VAL)
//     i_d    in  asynchronous input
//     o_q    out synchronised level, 2 clk cycles behind i_d
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_byte_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
//   8N1 UART receiver: deserialises frames on rxd into bytes and offers them
//   through a one-entry holding register with a valid/ready handshake.
//
//   Ports:
//     clk        in   system clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     rxd        in   raw serial line (asynchronous, idle high)
//     rx_data    out  [7:0] received byte, stable while rx_valid=1
//     rx_valid   out  holding register full
//     rx_ready   in   consumer accepts the byte on rx_valid & rx_ready
//     frame_err  out  one-cycle pulse, stop bit sampled low
//     overrun    out  one-cycle pulse, byte completed while holding register
//                     full and not being drained (new byte dropped)
//     rx_busy    out  high from start-bit detection until back in IDLE
//     dbg_state  out  [2:0] current FSM state (uart_rx_state_t encoding)
//
//   Handshake: a transfer happens on every cycle with rx_valid & rx_ready.
//   rx_data never changes while rx_valid=1 unless a transfer happens in that
//   cycle; rx_valid drops the cycle after a transfer unless a new byte is
//   loaded in the same cycle. rx_ready may be tied high.
//
//   Build option UART_RX_MAJORITY_EN: every start/data/stop sample becomes a
//   2-of-3 vote over the synchronised line at nominal-1, nominal, nominal+1.
//   The decision is taken one cycle after the nominal point while the bit
//   counter keeps its nominal phase, so sample spacing does not drift.
// -----------------------------------------------------------------------------
module uart_byte_rx
    import enigma_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy,
    output logic [2:0] dbg_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    // ---------------------------------------------------------------- sync
    logic w_rxs;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rxd),
        .o_q   (w_rxs)
    );

    // ------------------------------------------------------------- signals
    uart_rx_state_t r_state;
    uart_rx_state_t w_state_nxt;

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ferr;
    logic          r_ovr;

    logic w_timing;    // a bit period is being timed (START/DATA/STOP)
    logic w_tick;      // nominal sample point reached
    logic w_decide;    // sample decision taken this cycle
    logic w_bit;       // sampled bit value used by the decision
    logic w_shift_en;
    logic w_done;
    logic w_ferr_set;

    // START waits half a bit, DATA/STOP wait a full bit.
    assign w_tick = w_timing &&
                    ((r_state == START) ? (r_cnt == HALF_LAST) : (r_cnt == FULL_LAST));

`ifdef UART_RX_MAJORITY_EN
    logic r_rxs_d1;
    logic r_rxs_d2;
    logic r_pend;

    // r_pend marks the cycle after the nominal point, when the three-sample
    // window (d2 = nominal-1, d1 = nominal, w_rxs = nominal+1) is complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxs_d1 <= 1'b1;
            r_rxs_d2 <= 1'b1;
            r_pend   <= 1'b0;
        end else begin
            r_rxs_d1 <= w_rxs;
            r_rxs_d2 <= r_rxs_d1;
            r_pend   <= w_tick;
        end
    end

    assign w_decide = r_pend;
    assign w_bit    = maj3(r_rxs_d2, r_rxs_d1, w_rxs);
`else
    assign w_decide = w_tick;
    assign w_bit    = w_rxs;
`endif

    // ------------------------------------------------------ state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!w_rxs) w_state_nxt = START;
            START:   if (w_decide) w_state_nxt = w_bit ? IDLE : DATA;
            DATA:    if (w_decide && (r_bit_idx == 3'd7)) w_state_nxt = STOP;
            // A good stop bit returns straight to IDLE so a back-to-back
            // start edge is seen half a bit later.
            STOP:    if (w_decide) w_state_nxt = w_bit ? IDLE : BREAK;
            BREAK:   if (w_rxs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------- outputs
    always_comb begin
        w_timing   = (r_state == START) || (r_state == DATA) || (r_state == STOP);
        rx_busy    = (r_state != IDLE);
        w_shift_en = (r_state == DATA) && w_decide;
        w_done     = (r_state == STOP) && w_decide && w_bit;
        w_ferr_set = (r_state == STOP) && w_decide && !w_bit;
    end

    // -------------------------------------------------- counters and shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            // Counter restarts at every nominal sample point so each later
            // sample lands mid-bit.
            if (!w_timing || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if ((r_state == START) && w_decide) begin
                r_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end

            // LSB arrives first, so shift in from the top.
            if (w_shift_en) begin
                r_shift <= {w_bit, r_shift[7:1]};
            end
        end
    end

    // --------------------------------------------------- holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_ferr_set;
            r_ovr  <= 1'b0;
            if (w_done) begin
                if (!r_valid || rx_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_byte_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_byte_rx
//   Directed bench for uart_byte_rx at 104 clocks per bit.
// -----------------------------------------------------------------------------
module tb_uart_byte_rx;
  import enigma_pkg::*;

  localparam int CPB  = 104;
  localparam int HALF = CPB / 2;

  // ------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;
  logic rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid;
  logic frame_err;
  logic overrun;
  logic rx_busy;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_byte_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy),
    .dbg_state (dbg_state)
  );

  // ------------------------------------------------------------ scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] rcv_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------- monitor
  int n_ferr = 0;
  int n_ovr = 0;
  int n_valid_cyc = 0;
  int n_hs = 0;
  int n_unstable = 0;
  int last_rise_cyc = 0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (rx_valid) n_valid_cyc++;
    if (rx_valid && !prev_valid) last_rise_cyc = cyc;
    if (prev_valid && !prev_ready && rx_valid && (rx_data !== prev_data)) n_unstable++;
    if (rx_valid && rx_ready) begin
      n_hs++;
      rcv_q.push_back(rx_data);
    end
    prev_valid = rx_valid;
    prev_ready = rx_ready;
    prev_data  = rx_data;
  end

  // ------------------------------------------------------------- drivers
  int t_fall = 0;

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives nslots bit slots of an 8N1 frame (start, 8 data LSB first, stop).
  // With glitch set, each data bit is inverted for the single cycle that the
  // receiver uses as its nominal sample point.
  task automatic send_bits(input logic [7:0] data, input logic stop_v,
                           input logic glitch, input int nslots);
    logic [9:0] frame;
    logic v;
    frame = {stop_v, data, 1'b0};
    for (int b = 0; b < nslots; b++) begin
      for (int k = 0; k < CPB; k++) begin
        @(posedge clk);
        #1;
        v = frame[b];
        if (glitch && (b >= 1) && (b <= 8) && (k == HALF)) v = ~v;
        rxd = v;
        if ((b == 0) && (k == 0)) t_fall = cyc;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] data);
    send_bits(data, 1'b1, 1'b0, 10);
  endtask

  task automatic compare_rcv(input string tag);
    check({tag, "_count"}, rcv_q.size(), exp_q.size());
    while ((exp_q.size() > 0) && (rcv_q.size() > 0)) begin
      check(tag, rcv_q.pop_front(), exp_q.pop_front());
    end
    exp_q.delete();
    rcv_q.delete();
  endtask

  // ------------------------------------------------------------ sequence
  int b_ferr, b_ovr, b_valid, b_hs;
  int lat;
  logic [7:0] glitch_exp;

  task automatic snap();
    b_ferr  = n_ferr;
    b_ovr   = n_ovr;
    b_valid = n_valid_cyc;
    b_hs    = n_hs;
  endtask

  initial begin
    // Reset values
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_rx_busy", rx_busy, 1'b0);
    check("rst_state", dbg_state, IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx_ready = 1'b1;
    wait_cycles(20);

    // Single byte, latency and one-cycle valid
    snap();
    exp_q.push_back(8'h41);
    send_frame(8'h41);
    wait_cycles(20);
    lat = last_rise_cyc - t_fall;
    check("latency_991pm2", (lat >= 989) && (lat <= 993), 1'b1);
    check("single_valid_cycles", n_valid_cyc - b_valid, 1);
    check("single_ferr", n_ferr - b_ferr, 0);
    check("single_ovr", n_ovr - b_ovr, 0);
    compare_rcv("single_byte");

    // Back-to-back frames
    snap();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    send_frame(8'h00);
    send_frame(8'hFF);
    send_frame(8'h55);
    send_frame(8'hAA);
    wait_cycles(20);
    check("b2b_ovr", n_ovr - b_ovr, 0);
    check("b2b_ferr", n_ferr - b_ferr, 0);
    compare_rcv("b2b_byte");

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    snap();
    send_frame(8'h12);
    send_frame(8'h34);
    wait_cycles(20);
    @(negedge clk);
    check("ovr_valid_held", rx_valid, 1'b1);
    check("ovr_data_held", rx_data, 8'h12);
    check("ovr_pulse", n_ovr - b_ovr, 1);
    exp_q.push_back(8'h12);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    wait_cycles(5);
    @(negedge clk);
    check("ovr_valid_drop", rx_valid, 1'b0);
    check("ovr_handshakes", n_hs - b_hs, 1);
    compare_rcv("ovr_byte");

    // Framing error followed by a long break
    snap();
    send_bits(8'h5A, 1'b0, 1'b0, 10);
    repeat (2000) @(posedge clk);
    #1;
    rxd = 1'b1;
    wait_cycles(2 * CPB);
    check("brk_ferr", n_ferr - b_ferr, 1);
    check("brk_no_valid", n_valid_cyc - b_valid, 0);
    check("brk_busy_clear", rx_busy, 1'b0);
    exp_q.push_back(8'h33);
    send_frame(8'h33);
    wait_cycles(20);
    compare_rcv("after_brk_byte");

    // False start from a 20-cycle low pulse
    snap();
    @(posedge clk);
    #1;
    rxd = 1'b0;
    wait_cycles(10);
    check("fs_busy_high", rx_busy, 1'b1);
    wait_cycles(10);
    rxd = 1'b1;
    wait_cycles(CPB);
    check("fs_busy_low", rx_busy, 1'b0);
    check("fs_no_valid", n_valid_cyc - b_valid, 0);
    check("fs_no_ferr", n_ferr - b_ferr, 0);
    check("fs_no_ovr", n_ovr - b_ovr, 0);

    // Reset in the middle of a frame
    snap();
    send_bits(8'hC3, 1'b1, 1'b0, 5);
    rst_n = 1'b0;
    rxd = 1'b1;
    wait_cycles(5);
    check("mid_rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    wait_cycles(2 * CPB);
    check("mid_rst_no_ferr", n_ferr - b_ferr, 0);
    check("mid_rst_no_valid", n_valid_cyc - b_valid, 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E);
    wait_cycles(20);
    compare_rcv("after_rst_byte");

    // Single-cycle glitch at each data bit's sample point
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h0F;
`else
    glitch_exp = 8'hF0;
`endif
    snap();
    exp_q.push_back(glitch_exp);
    send_bits(8'h0F, 1'b1, 1'b1, 10);
    wait_cycles(20);
    check("glitch_ferr", n_ferr - b_ferr, 0);
    compare_rcv("glitch_byte");

    check("data_stable", n_unstable, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
